// File: rtl/demux_pkg.sv
// Shared constants for the stream demultiplexer: mode encodings and the
// supported output channel range.
package demux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    localparam int N_MIN = 2;
    localparam int N_MAX = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a single word with its valid flag.
// A load wins over a drain, so a word can pass straight through every cycle.
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // data register: captures on load, otherwise keeps its last word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

    // occupancy flag: set by load, cleared only by a drain without a load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each accepted input word to one of N one-entry
// channel slots, chosen by an explicit select or by an auto-incrementing pointer.
module demux_stream
    import demux_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   d,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [SW-1:0]  s,
    input  logic           mode,
    output logic [N*W-1:0] y,
    output logic [N-1:0]   y_valid,
    input  logic [N-1:0]   y_ready,
    output logic [SW-1:0]  ptr,
    output logic           err
);

    localparam logic [SW:0]   N_LIM    = (SW+1)'(N);
    localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("demux_stream: N outside supported range");
    end

    logic [SW-1:0] r_ptr;
    logic          r_err;
    logic [SW-1:0] w_t;
    logic          w_oor;
    logic          w_in_ready;
    logic          w_accept;
    logic [N-1:0]  w_load;
    logic [N-1:0]  w_drain;

    assign w_t      = (mode == MODE_SCAN) ? r_ptr : s;
    assign w_oor    = ({1'b0, w_t} >= N_LIM);
    assign w_accept = in_valid & w_in_ready;
    assign w_drain  = y_valid & y_ready;
    assign in_ready = w_in_ready;
    assign ptr      = r_ptr;
    assign err      = r_err;

    // target slot readiness and per-slot load strobes; out-of-range targets always accept
    always_comb begin
        w_in_ready = 1'b1;
        w_load     = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_oor && (w_t == SW'(k))) begin
                w_in_ready = ~y_valid[k] | y_ready[k];
                w_load[k]  = in_valid & (~y_valid[k] | y_ready[k]);
            end else begin
                w_load[k]  = 1'b0;
            end
        end
    end

    // scan pointer: advances only on a scan-mode accept, wrapping at N-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept && (mode == MODE_SCAN)) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + SW'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // dropped-word flag: one-cycle pulse after an out-of-range accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & w_oor;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (w_load[g]),
            .drain (w_drain[g]),
            .d     (d),
            .q     (y[g*W +: W]),
            .valid (y_valid[g])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: per-channel scoreboard queues for the
// N=4 instance plus directed checks, and an N=3 instance for out-of-range drops.
module tb_demux_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  d;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  s;
    logic        mode;
    logic [31:0] y;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic [1:0]  ptr;
    logic        err;

    logic [7:0]  d3;
    logic        iv3;
    logic        ir3;
    logic [1:0]  s3;
    logic        mode3;
    logic [23:0] y3;
    logic [2:0]  yv3;
    logic [2:0]  yr3;
    logic [1:0]  ptr3;
    logic        err3;

    int          n_checks;
    int          n_errors;
    int          n_pops;
    int          m_ptr;
    logic        m_err;
    logic [7:0]  sbq [4][$];

    demux_stream #(.W(8), .N(4)) dut (
        .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .mode(mode), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .ptr(ptr), .err(err)
    );

    demux_stream #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .d(d3), .in_valid(iv3), .in_ready(ir3),
        .s(s3), .mode(mode3), .y(y3), .y_valid(yv3), .y_ready(yr3),
        .ptr(ptr3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the N=4 instance: compare against the model at negedge,
    // retire drains, record accepts, then step past the next posedge.
    task automatic cycle();
        int   t;
        logic exp_rdy;
        logic [7:0] exp_d;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq("valid", y_valid[k], sbq[k].size() != 0);
        end
        t = (mode == 1'b1) ? m_ptr : int'(s);
        exp_rdy = (t >= 4) || (sbq[t].size() == 0) || y_ready[t];
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("ptr", ptr, m_ptr);
        check_eq("err", err, m_err);
        for (int k = 0; k < 4; k++) begin
            if (y_valid[k] && y_ready[k] && sbq[k].size() != 0) begin
                exp_d = sbq[k].pop_front();
                check_eq("data", y[k*8 +: 8], exp_d);
                n_pops++;
            end
        end
        m_err = in_valid && exp_rdy && (t >= 4);
        if (in_valid && exp_rdy && t < 4) sbq[t].push_back(d);
        if (in_valid && exp_rdy && mode == 1'b1) m_ptr = (m_ptr + 1) % 4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; n_pops = 0; m_ptr = 0; m_err = 1'b0;
        rst = 1'b1; d = 8'h00; in_valid = 1'b0; s = 2'd0; mode = 1'b0; y_ready = 4'h0;
        d3 = 8'h00; iv3 = 1'b0; s3 = 2'd0; mode3 = 1'b0; yr3 = 3'b000;
        #1;
        check_eq("rst_valid", y_valid, 4'h0);
        check_eq("rst_y", y, 32'h0);
        check_eq("rst_ptr", ptr, 2'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_valid3", yv3, 3'b000);
        check_eq("rst_ptr3", ptr3, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // scan mode wrap: 6 words over 4 channels
        mode = 1'b1; y_ready = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            d = 8'(i); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check_eq("scan_ptr", ptr, 2'd2);

        // addressed write, then a held second write to the same full slot
        mode = 1'b0; y_ready = 4'h0; s = 2'd2; d = 8'hA5; in_valid = 1'b1;
        cycle();
        d = 8'h5A;
        #1;
        check_eq("addr_valid", y_valid, 4'b0100);
        check_eq("addr_data", y[23:16], 8'hA5);
        check_eq("addr_hold", in_ready, 1'b0);
        cycle();
        cycle();
        y_ready = 4'b0100;
        cycle();
        in_valid = 1'b0; y_ready = 4'h0;
        check_eq("addr_pass", y[23:16], 8'h5A);
        check_eq("addr_valid2", y_valid, 4'b0100);
        y_ready = 4'hF;
        cycle();

        // full-rate stream on channel 1
        mode = 1'b0; s = 2'd1; y_ready = 4'b0010; in_valid = 1'b1; n_pops = 0;
        for (int i = 0; i < 10; i++) begin
            d = 8'h30 + 8'(i);
            #1;
            check_eq("fr_rdy", in_ready, 1'b1);
            if (i > 0) check_eq("fr_valid", y_valid[1], 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check_eq("fr_count", n_pops, 10);

        // out-of-range select on the N=3 instance
        mode3 = 1'b0; s3 = 2'd0; d3 = 8'h11; iv3 = 1'b1; yr3 = 3'b000;
        @(posedge clk);
        #1;
        s3 = 2'd3; d3 = 8'hFF;
        #1;
        check_eq("oor_rdy", ir3, 1'b1);
        check_eq("oor_err_pre", err3, 1'b0);
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        check_eq("oor_err", err3, 1'b1);
        check_eq("oor_valid", yv3, 3'b001);
        check_eq("oor_y", y3, 24'h000011);
        @(posedge clk);
        #1;
        check_eq("oor_err_end", err3, 1'b0);
        check_eq("oor_valid_end", yv3, 3'b001);

        // reset mid-operation with all slots full
        mode = 1'b0; y_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k); d = 8'h40 + 8'(k); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", y_valid, 4'h0);
        check_eq("mid_rst_ptr", ptr, 2'd0);
        check_eq("mid_rst_y", y, 32'h0);
        for (int k = 0; k < 4; k++) sbq[k].delete();
        m_ptr = 0; m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; mode = 1'b1; d = 8'h77; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check_eq("post_rst_valid", y_valid, 4'b0001);
        check_eq("post_rst_data", y[7:0], 8'h77);

        // mode switch keeps the scan pointer
        y_ready = 4'hF; mode = 1'b1; in_valid = 1'b1;
        d = 8'h81; cycle();
        d = 8'h82; cycle();
        check_eq("sw_ptr3", ptr, 2'd3);
        mode = 1'b0; s = 2'd0; d = 8'h90; cycle();
        check_eq("sw_ptr_hold", ptr, 2'd3);
        mode = 1'b1; d = 8'hC3; y_ready = 4'h0; cycle();
        in_valid = 1'b0;
        check_eq("sw_valid3", y_valid[3], 1'b1);
        check_eq("sw_data3", y[31:24], 8'hC3);
        check_eq("sw_ptr_wrap", ptr, 2'd0);
        y_ready = 4'hF;
        cycle();
        cycle();
        check_eq("sb_left", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter W, default 8, data width per channel.
REQ-002 Parameter N, default 4, output channel count, range 2..16, need not be a power of two.
REQ-003 Parameter SW, default $clog2(N), select/pointer width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 d  input  W  input data word.
REQ-008 in_valid  input  1  d is presented.
REQ-009 in_ready  output  1  block accepts d this cycle.
REQ-010 s  input  SW  addressed channel select, used in mode 0.
REQ-011 mode  input  1  0 = addressed, 1 = scan (auto-increment).
REQ-012 y  output  N*W  channel data, channel k at bits [k*W +: W].
REQ-013 y_valid  output  N  per-channel data-held flag.
REQ-014 y_ready  input  N  per-channel consumer takes data.
REQ-015 ptr  output  SW  current scan pointer.
REQ-016 err  output  1  one-cycle pulse on a dropped out-of-range word.

Function
REQ-017 Target channel t SHALL be s in mode 0 and ptr in mode 1, sampled in the same cycle as in_valid.
REQ-018 Each channel SHALL hold one word in a one-entry slot with its own valid flag.
REQ-019 in_ready SHALL be 1 when t >= N, when slot t is empty, or when y_ready[t] is 1. It SHALL be combinational from current state, s, mode and y_ready.
REQ-020 Accept is in_valid and in_ready. On accept with t < N, the block SHALL load d into slot t and set y_valid[t] at the next rising edge, giving one-cycle latency.
REQ-021 Drain is y_valid[k] and y_ready[k]. On drain without a load, the block SHALL clear y_valid[k] at the next edge.
REQ-022 Simultaneous drain and load on the same channel SHALL load the new word and keep y_valid at 1, so a full-rate stream passes with no bubble.
REQ-023 Drains on other channels SHALL proceed independently in the same cycle as a load.
REQ-024 In mode 1, each accept SHALL advance ptr by 1, wrapping from N-1 to 0. ptr SHALL NOT advance in mode 0 or without an accept.
REQ-025 A mode change SHALL take effect in the same cycle. ptr SHALL retain its value across mode changes.
REQ-026 In mode 0, s >= N SHALL accept and discard the word (in_ready = 1), pulse err for one cycle at the next edge, and leave all slots unchanged.
REQ-027 y[k] SHALL hold its last value while y_valid[k] = 0. Its value is not meaningful in that state.
REQ-028 Unselected channels SHALL never change data or valid, except by their own drain.

Reset
REQ-029 rst = 1 SHALL immediately force y_valid = 0, y = 0, ptr = 0 and err = 0, independent of clk.
REQ-030 Words in flight at reset assertion SHALL be discarded.
REQ-031 After rst falls, the first accept SHALL be possible on the first rising edge.

Structure
REQ-032 Shared package demux_pkg SHALL hold the mode constants (MODE_ADDR = 0, MODE_SCAN = 1) and the N range limits.
REQ-033 The per-channel slot SHALL be sub-module demux_slot, instantiated N times by generate. Its ports are clk, rst, load, drain, d, q, valid.
REQ-034 The pointer/wrap logic and in_ready mux SHALL stay in demux_stream.

Verification (W=8, N=4 unless stated)
REQ-035 Addressed mode: mode=0, s=2, d=8'hA5, in_valid=1 for 1 cycle, y_ready=0 -> y_valid=4'b0100 and y[23:16]=A5 one cycle later. A second write to s=2 -> in_ready=0, and the word is held upstream.
REQ-036 Scan wrap: mode=1, 6 accepts of 01..06, y_ready=all 1 -> channels receive 01,02,03,04,05,06 on ch0,1,2,3,0,1. ptr reads 2 at the end.
REQ-037 Full rate: mode=0, s=1, in_valid=1 and y_ready[1]=1 continuously for 10 cycles -> in_ready stays 1, y_valid[1] stays 1, 10 distinct words appear in order.
REQ-038 Out of range: N=3, mode=0, s=3, d=8'hFF -> in_ready=1, err=1 for exactly one cycle, y_valid unchanged.
REQ-039 Reset mid-operation: fill all 4 slots, then assert rst between edges -> y_valid=0 and ptr=0 before the next edge. After release, a scan write lands in ch0.
REQ-040 Mode switch: ptr=3 in mode 1, switch to mode 0 with s=0 and write, then return to mode 1 and write -> the second word lands in ch3, and ptr becomes 0.
